// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Initiator side of the ALU operand/select interface. Accepts
//            32-bit instructions over valid/ready and owns an 8x8-bit
//            register file. For each instruction it reads the source
//            registers, drives DATA1/DATA2/SELECT, holds them for ALU_WAIT
//            cycles, then writes RESULT back to the destination register.
//            Optional build macro: ZERO_FLAG_EN adds a ZERO output that
//            reflects the most recent write-back value.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int ALU_WAIT = 1  // cycles ALU inputs are held; legal 1..15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  output logic [7:0]  alu_data1_o,
  output logic [7:0]  alu_data2_o,
  output logic [2:0]  alu_select_o,
  input  logic [7:0]  alu_result_i,
  output logic        done_o,
  output logic        err_o,
`ifdef ZERO_FLAG_EN
  output logic        zero_o,
`endif
  input  logic [2:0]  dbg_addr_i,
  output logic [7:0]  dbg_data_o
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  // Opcodes
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  // ALU function selects (the 1xx half of the space is never driven)
  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;

  // Counter reload: EXEC lasts ALU_WAIT cycles, the last one at count 0
  localparam logic [3:0] C_WAIT_LOAD = 4'(ALU_WAIT - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0] state_q, state_d;

  // Latched instruction fields; only the low 3 bits of each register field
  // matter, so the rest is never stored.
  logic [7:0] op_q,  op_d;
  logic [2:0] rd_q,  rd_d;
  logic [2:0] rs1_q, rs1_d;
  logic [7:0] rs2_q, rs2_d;  // RS2 index in [2:0], or full 8-bit IMM

  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic [2:0] sel_q,   sel_d;
  logic       done_q,  done_d;
  logic       err_q,   err_d;
  logic       ready_q, ready_d;
  logic [3:0] cnt_q,   cnt_d;

  logic [7:0] regs_q [8];

  logic       wr_en;
  logic       op_legal;
  logic       exec_last;
  logic [7:0] rs1_val;
  logic [7:0] rs2_val;
  logic [7:0] rs2_neg;

  // Upper register-field bits are architecturally ignored
  logic       unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr_i[23:19], instr_i[15:11]};

  // Source operand reads happen in READ, before any write to the same index
  assign rs1_val   = regs_q[rs1_q];
  assign rs2_val   = regs_q[rs2_q[2:0]];
  assign rs2_neg   = ~rs2_val + 8'd1;
  assign exec_last = (cnt_q == 4'd0);

  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: op_legal = 1'b1;
      default:                                         op_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (instr_valid_i) state_d = S_READ;
      S_READ: state_d = op_legal ? S_EXEC : S_WB;
      S_EXEC: if (exec_last) state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output / datapath next-value logic
  // --------------------------------------------------------------------------
  always_comb begin
    op_d    = op_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    sel_d   = sel_q;
    done_d  = done_q;
    err_d   = err_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The instruction is sampled only on the accept edge
        if (instr_valid_i) begin
          op_d    = instr_i[31:24];
          rd_d    = instr_i[18:16];
          rs1_d   = instr_i[10:8];
          rs2_d   = instr_i[7:0];
          ready_d = 1'b0;
        end
      end

      S_READ: begin
        cnt_d = C_WAIT_LOAD;
        case (op_q)
          OP_LOADI: begin
            data2_d = rs2_q;
            sel_d   = SEL_PASS;
          end
          OP_MOV: begin
            data2_d = rs2_val;
            sel_d   = SEL_PASS;
          end
          OP_ADD: begin
            data1_d = rs1_val;
            data2_d = rs2_val;
            sel_d   = SEL_ADD;
          end
          OP_SUB: begin
            // Subtraction is done as addition of the two's complement
            data1_d = rs1_val;
            data2_d = rs2_neg;
            sel_d   = SEL_ADD;
          end
          OP_AND: begin
            data1_d = rs1_val;
            data2_d = rs2_val;
            sel_d   = SEL_AND;
          end
          OP_OR: begin
            data1_d = rs1_val;
            data2_d = rs2_val;
            sel_d   = SEL_OR;
          end
          default: begin
            // Illegal opcode: ALU outputs keep their previous values
            err_d = 1'b1;
          end
        endcase
      end

      S_EXEC: begin
        if (exec_last) begin
          wr_en  = 1'b1;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_WB: begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        ready_d = 1'b1;
      end

      default: begin
        ready_d = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and handshake registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
      sel_q   <= SEL_PASS;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Register file: single write port, written on the last EXEC edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd_q] <= alu_result_i;
    end
  end

`ifdef ZERO_FLAG_EN
  logic zero_q;

  // Zero flag tracks the last write-back only; ERR and idle cycles hold it
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      zero_q <= 1'b0;
    end else if (wr_en) begin
      zero_q <= (alu_result_i == 8'd0);
    end
  end

  assign zero_o = zero_q;
`endif

  assign instr_ready_o = ready_q;
  assign alu_data1_o   = data1_q;
  assign alu_data2_o   = data2_q;
  assign alu_select_o  = sel_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign dbg_data_o    = regs_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Directed self-checking bench for alu_issue_ctrl. One instance
//            with ALU_WAIT=1 and one with ALU_WAIT=3, each fed by a small
//            behavioural ALU. Build with ZERO_FLAG_EN to cover the ZERO flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r_instr;
  logic        r_valid1, r_valid3;
  logic [2:0]  r_dbg_addr;

  logic        w_ready1, w_done1, w_err1;
  logic [7:0]  w_d1_1, w_d2_1, w_res1, w_dbg1;
  logic [2:0]  w_sel1;
  logic        w_ready3, w_done3, w_err3;
  logic [7:0]  w_d1_3, w_d2_3, w_res3, w_dbg3;
  logic [2:0]  w_sel3;
`ifdef ZERO_FLAG_EN
  logic        w_zero1, w_zero3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: 000 pass DATA2, 001 add, 010 and, 011 or
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] s);
    case (s)
      3'b000:  return b;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return 8'h00;
    endcase
  endfunction

  assign w_res1 = alu_model(w_d1_1, w_d2_1, w_sel1);
  assign w_res3 = alu_model(w_d1_3, w_d2_3, w_sel3);

  alu_issue_ctrl #(.ALU_WAIT(1)) u_dut1 (
    .clk_i        (clk),
    .reset_i      (rst),
    .instr_i      (r_instr),
    .instr_valid_i(r_valid1),
    .instr_ready_o(w_ready1),
    .alu_data1_o  (w_d1_1),
    .alu_data2_o  (w_d2_1),
    .alu_select_o (w_sel1),
    .alu_result_i (w_res1),
    .done_o       (w_done1),
    .err_o        (w_err1),
`ifdef ZERO_FLAG_EN
    .zero_o       (w_zero1),
`endif
    .dbg_addr_i   (r_dbg_addr),
    .dbg_data_o   (w_dbg1)
  );

  alu_issue_ctrl #(.ALU_WAIT(3)) u_dut3 (
    .clk_i        (clk),
    .reset_i      (rst),
    .instr_i      (r_instr),
    .instr_valid_i(r_valid3),
    .instr_ready_o(w_ready3),
    .alu_data1_o  (w_d1_3),
    .alu_data2_o  (w_d2_3),
    .alu_select_o (w_sel3),
    .alu_result_i (w_res3),
    .done_o       (w_done3),
    .err_o        (w_err3),
`ifdef ZERO_FLAG_EN
    .zero_o       (w_zero3),
`endif
    .dbg_addr_i   (r_dbg_addr),
    .dbg_data_o   (w_dbg3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Debug-port register read; called just after a falling edge
  task automatic chk_reg(input string tag, input bit use3, input logic [2:0] idx,
                         input logic [7:0] exp);
    r_dbg_addr = idx;
    #1;
    check(tag, use3 ? w_dbg3 : w_dbg1, exp);
  endtask

  // Issue one instruction to the ALU_WAIT=1 instance and wait for completion
  task automatic exec1(input logic [31:0] ins);
    int n;
    @(negedge clk);
    r_instr  = ins;
    r_valid1 = 1'b1;
    @(negedge clk);
    r_valid1 = 1'b0;
    n = 0;
    while (!(w_done1 || w_err1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("exec1_complete", 32'(w_done1 | w_err1), 32'd1);
    @(negedge clk);
  endtask

  // Issue one instruction to the ALU_WAIT=3 instance and wait for completion
  task automatic exec3(input logic [31:0] ins);
    int n;
    @(negedge clk);
    r_instr  = ins;
    r_valid3 = 1'b1;
    @(negedge clk);
    r_valid3 = 1'b0;
    n = 0;
    while (!(w_done3 || w_err3) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("exec3_complete", 32'(w_done3 | w_err3), 32'd1);
    @(negedge clk);
  endtask

  logic [7:0] exp_r [8];

  initial begin
    int n;
    rst        = 1'b1;
    r_instr    = '0;
    r_valid1   = 1'b0;
    r_valid3   = 1'b0;
    r_dbg_addr = '0;
    repeat (3) @(negedge clk);

    // ---------------- reset state ----------------
    check("rst_ready", 32'(w_ready1), 32'd1);
    check("rst_data1", 32'(w_d1_1), 32'h00);
    check("rst_data2", 32'(w_d2_1), 32'h00);
    check("rst_sel",   32'(w_sel1), 32'h0);
    check("rst_done",  32'(w_done1), 32'd0);
    check("rst_err",   32'(w_err1), 32'd0);
`ifdef ZERO_FLAG_EN
    check("rst_zero",  32'(w_zero1), 32'd0);
`endif
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 1'b0, 3'(i), 8'h00);
    rst = 1'b0;

    // ---------------- LOADI R1,0x05 with explicit timing ----------------
    @(negedge clk);
    r_instr  = {8'h00, 8'h01, 8'h00, 8'h05};
    r_valid1 = 1'b1;
    @(negedge clk);                       // after E0
    r_valid1 = 1'b0;
    check("t1_busy_e0", 32'(w_ready1), 32'd0);
    @(negedge clk);                       // after E1: EXEC
    check("t1_data2", 32'(w_d2_1), 32'h05);
    check("t1_sel",   32'(w_sel1), 32'h0);
    check("t1_nodone_e1", 32'(w_done1), 32'd0);
    chk_reg("t1_r1_before_wr", 1'b0, 3'd1, 8'h00);
    @(negedge clk);                       // after E2: write + DONE
    check("t1_done", 32'(w_done1), 32'd1);
    check("t1_busy_e2", 32'(w_ready1), 32'd0);
    chk_reg("t1_r1", 1'b0, 3'd1, 8'h05);
    @(negedge clk);                       // after E3: ready again
    check("t1_done_clr", 32'(w_done1), 32'd0);
    check("t1_ready_e3", 32'(w_ready1), 32'd1);

    // ---------------- LOADI R2; SUB R3,R2,R1 ----------------
    exec1({8'h00, 8'h02, 8'h00, 8'h0C});
    chk_reg("t2_r2", 1'b0, 3'd2, 8'h0C);
    @(negedge clk);
    r_instr  = {8'h03, 8'h03, 8'h02, 8'h01};
    r_valid1 = 1'b1;
    @(negedge clk);
    r_valid1 = 1'b0;
    @(negedge clk);                       // EXEC
    check("sub_data1", 32'(w_d1_1), 32'h0C);
    check("sub_data2", 32'(w_d2_1), 32'hFB);
    check("sub_sel",   32'(w_sel1), 32'h1);
    @(negedge clk);
    check("sub_done", 32'(w_done1), 32'd1);
    chk_reg("sub_r3", 1'b0, 3'd3, 8'h07);
    @(negedge clk);

    // ---------------- AND / OR / ADD ----------------
    exec1({8'h04, 8'h04, 8'h02, 8'h01});
    chk_reg("and_r4", 1'b0, 3'd4, 8'h04);
    exec1({8'h05, 8'h05, 8'h02, 8'h01});
    chk_reg("or_r5", 1'b0, 3'd5, 8'h0D);
    // Upper field bits set: RD=0xFE->6, RS1=0xFA->2, RS2=0x02->2
    exec1({8'h02, 8'hFE, 8'hFA, 8'h02});
    chk_reg("add_r6", 1'b0, 3'd6, 8'h18);
    exec1({8'h00, 8'h00, 8'h00, 8'h01});
    exec1({8'h00, 8'h07, 8'h00, 8'hFF});
`ifdef ZERO_FLAG_EN
    check("zero_nonzero", 32'(w_zero1), 32'd0);
`endif
    exec1({8'h02, 8'h07, 8'h07, 8'h00});  // R7 = R7 + R0 = 0xFF + 0x01
    chk_reg("add_wrap_r7", 1'b0, 3'd7, 8'h00);
`ifdef ZERO_FLAG_EN
    check("zero_set", 32'(w_zero1), 32'd1);
`endif

    // ---------------- illegal opcode 0x07 ----------------
    exp_r[0] = 8'h01; exp_r[1] = 8'h05; exp_r[2] = 8'h0C; exp_r[3] = 8'h07;
    exp_r[4] = 8'h04; exp_r[5] = 8'h0D; exp_r[6] = 8'h18; exp_r[7] = 8'h00;
    @(negedge clk);
    r_instr  = {8'h07, 8'h01, 8'h02, 8'h03};
    r_valid1 = 1'b1;
    @(negedge clk);
    r_valid1 = 1'b0;
    check("err_busy", 32'(w_ready1), 32'd0);
    @(negedge clk);                       // after E1
    check("err_pulse", 32'(w_err1), 32'd1);
    check("err_nodone", 32'(w_done1), 32'd0);
    check("err_sel_kept", 32'(w_sel1), 32'h1);
    @(negedge clk);                       // after E2
    check("err_clr", 32'(w_err1), 32'd0);
    check("err_nodone2", 32'(w_done1), 32'd0);
    check("err_ready", 32'(w_ready1), 32'd1);
`ifdef ZERO_FLAG_EN
    check("zero_held", 32'(w_zero1), 32'd1);
`endif
    for (int i = 0; i < 8; i++) chk_reg("err_regs", 1'b0, 3'(i), exp_r[i]);
    exec1({8'h01, 8'h00, 8'h00, 8'h03});  // MOV R0,R3
    chk_reg("post_err_mov_r0", 1'b0, 3'd0, 8'h07);
`ifdef ZERO_FLAG_EN
    check("zero_clr", 32'(w_zero1), 32'd0);
`endif

    // ---------------- reset during EXEC ----------------
    @(negedge clk);
    r_instr  = {8'h00, 8'h01, 8'h00, 8'hAA};
    r_valid1 = 1'b1;
    @(negedge clk);
    r_valid1 = 1'b0;
    @(negedge clk);                       // EXEC
    rst      = 1'b1;
    r_valid1 = 1'b1;                      // must not be accepted under reset
    @(negedge clk);
    check("rstx_nodone", 32'(w_done1), 32'd0);
    check("rstx_noerr",  32'(w_err1), 32'd0);
    check("rstx_ready",  32'(w_ready1), 32'd1);
    check("rstx_data1",  32'(w_d1_1), 32'h00);
    check("rstx_data2",  32'(w_d2_1), 32'h00);
    check("rstx_sel",    32'(w_sel1), 32'h0);
    chk_reg("rstx_r1", 1'b0, 3'd1, 8'h00);
    chk_reg("rstx_r5", 1'b0, 3'd5, 8'h00);
    @(negedge clk);
    check("rstx_no_accept", 32'(w_ready1), 32'd1);
    r_valid1 = 1'b0;
    rst      = 1'b0;

    // ---------------- ALU_WAIT=3, valid held, INSTR changing ----------------
    exec3({8'h00, 8'h05, 8'h00, 8'h0D});
    chk_reg("w3_r5", 1'b1, 3'd5, 8'h0D);
    @(negedge clk);
    r_instr  = {8'h01, 8'h00, 8'h00, 8'h05};  // MOV R0,R5
    r_valid3 = 1'b1;
    @(negedge clk);                           // after E0
    r_instr = {8'h00, 8'h00, 8'h00, 8'h77};
    check("w3_busy_e0", 32'(w_ready3), 32'd0);
    @(negedge clk);                           // after E1
    check("w3_data2", 32'(w_d2_3), 32'h0D);
    check("w3_sel",   32'(w_sel3), 32'h0);
    r_instr = {8'h02, 8'h01, 8'h01, 8'h01};
    @(negedge clk);                           // after E2
    check("w3_nodone_e2", 32'(w_done3), 32'd0);
    @(negedge clk);                           // after E3
    check("w3_nodone_e3", 32'(w_done3), 32'd0);
    check("w3_data2_held", 32'(w_d2_3), 32'h0D);
    @(negedge clk);                           // after E4
    check("w3_done_e4", 32'(w_done3), 32'd1);
    check("w3_busy_e4", 32'(w_ready3), 32'd0);
    chk_reg("w3_r0", 1'b1, 3'd0, 8'h0D);
    chk_reg("w3_r1_untouched", 1'b1, 3'd1, 8'h00);
    r_instr = {8'h00, 8'h00, 8'h00, 8'h77};
    @(negedge clk);                           // after E5
    check("w3_done_clr", 32'(w_done3), 32'd0);
    check("w3_ready_e5", 32'(w_ready3), 32'd1);
    @(negedge clk);                           // after E6: accepted
    check("w3_accept_e6", 32'(w_ready3), 32'd0);
    r_valid3 = 1'b0;
    n = 0;
    while (!w_done3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w3_second_done", 32'(w_done3), 32'd1);
    chk_reg("w3_r0_second", 1'b1, 3'd0, 8'h77);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
